// File: rtl/video_capture.sv
// Captures one complete frame from a display stream and writes it out as
// linear-indexed pixels through a small first-word fall-through buffer.
module video_capture #(
    parameter int BPC        = 5,
    parameter int H_RES      = 672,
    parameter int V_RES      = 384,
    parameter int ADDRW      = 18,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                 clk_pix,
    input  logic                 rst_pix,
    input  logic                 disp_de,
    input  logic                 disp_frame,
    input  logic [BPC-1:0]       disp_r,
    input  logic [BPC-1:0]       disp_g,
    input  logic [BPC-1:0]       disp_b,
    input  logic                 cap_start,
    output logic                 mem_valid,
    input  logic                 mem_ready,
    output logic [ADDRW-1:0]     mem_addr,
    output logic [3*BPC-1:0]     mem_data,
    output logic                 busy,
    output logic                 done,
    output logic                 overflow,
    output logic                 frame_err
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int DW = 3 * BPC;
    localparam int EW = ADDRW + DW;
    localparam logic [PW:0]      FULL_CNT = (PW + 1)'(FIFO_DEPTH);
    localparam logic [ADDRW-1:0] LAST_PIX = ADDRW'(H_RES * V_RES - 1);

    typedef enum logic [2:0] {IDLE, ARMED, CAPTURE, DRAIN, DONE} state_t;

    state_t           state;
    logic [ADDRW-1:0] pix_cnt;
    logic [EW-1:0]    fifo_mem [FIFO_DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [PW:0]      fifo_cnt;
    logic             fifo_full;
    logic             fifo_empty;
    logic             pixel_req;
    logic             push;
    logic             pop;

    // Fullness is judged on the registered count, so a same-cycle pop never frees a slot.
    assign fifo_full  = (fifo_cnt == FULL_CNT);
    assign fifo_empty = (fifo_cnt == '0);
    assign pixel_req  = (state == CAPTURE) && disp_de && !disp_frame;
    assign push       = pixel_req && !fifo_full;
    assign pop        = !fifo_empty && mem_ready;

    assign mem_valid             = !fifo_empty;
    assign {mem_addr, mem_data}  = fifo_empty ? '0 : fifo_mem[rd_ptr];

    // NOTE: the storage array has no reset; only pointers and count decide what is valid.
    always_ff @(posedge clk_pix) begin
        if (push) begin
            fifo_mem[wr_ptr] <= {pix_cnt, disp_r, disp_g, disp_b};
        end
    end

    always_ff @(posedge clk_pix) begin
        if (rst_pix) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + (PW + 1)'(1);
                2'b01:   fifo_cnt <= fifo_cnt - (PW + 1)'(1);
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    // NOTE: busy and done are registered alongside the state they decode, so they never glitch.
    always_ff @(posedge clk_pix) begin
        if (rst_pix) begin
            state     <= IDLE;
            pix_cnt   <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            overflow  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (cap_start) begin
                        state     <= ARMED;
                        busy      <= 1'b1;
                        overflow  <= 1'b0;
                        frame_err <= 1'b0;
                    end else begin
                        state <= IDLE;
                    end
                end
                ARMED: begin
                    if (disp_frame) begin
                        state   <= CAPTURE;
                        pix_cnt <= '0;
                    end
                end
                CAPTURE: begin
                    if (disp_frame) begin
                        frame_err <= 1'b1;
                        state     <= DRAIN;
                    end else if (disp_de) begin
                        if (fifo_full) overflow <= 1'b1;
                        pix_cnt <= pix_cnt + ADDRW'(1);
                        if (pix_cnt == LAST_PIX) state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (fifo_empty) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/video_capture.md
VIDEO_CAPTURE -- requirements
Module: video_capture

Interface
REQ-001 SHALL have parameter BPC, default 5: bits per colour channel of the incoming display stream.
REQ-002 SHALL have parameter H_RES, default 672: active pixels per line.
REQ-003 SHALL have parameter V_RES, default 384: active lines per frame.
REQ-004 SHALL have parameter ADDRW, default 18: pixel address width; H_RES*V_RES <= 2**ADDRW.
REQ-005 SHALL have parameter FIFO_DEPTH, default 16, a power of two >= 2: capture buffer entries.
REQ-006 SHALL have port clk_pix, input, 1: the single clock; all logic on its rising edge.
REQ-007 SHALL have port rst_pix, input, 1: synchronous active-high reset.
REQ-008 SHALL have port disp_de, input, 1: data enable, high for active pixels.
REQ-009 SHALL have port disp_frame, input, 1: one-cycle pulse at frame start, in blanking.
REQ-010 SHALL have ports disp_r, disp_g and disp_b, input, BPC each: pixel colour.
REQ-011 SHALL have port cap_start, input, 1: request capture of the next complete frame.
REQ-012 SHALL have port mem_valid, output, 1: write request valid.
REQ-013 SHALL have port mem_ready, input, 1: memory accepts the write this cycle.
REQ-014 SHALL have port mem_addr, output, ADDRW: linear pixel index, y*H_RES+x.
REQ-015 SHALL have port mem_data, output, 3*BPC: {r,g,b}, r in the MSBs.
REQ-016 SHALL have port busy, output, 1: high in ARMED, CAPTURE and DRAIN.
REQ-017 SHALL have port done, output, 1: one-cycle completion pulse.
REQ-018 SHALL have ports overflow and frame_err, output, 1 each: sticky error flags.

Function
REQ-019 SHALL implement states IDLE, ARMED, CAPTURE, DRAIN and DONE.
REQ-020 IDLE or DONE with cap_start=1 SHALL go to ARMED next cycle and clear overflow and frame_err; cap_start SHALL be ignored in ARMED, CAPTURE and DRAIN.
REQ-021 DONE SHALL last exactly one cycle and then go to IDLE unless cap_start; done SHALL be high only in DONE.
REQ-022 ARMED with disp_frame=1 SHALL go to CAPTURE with pix_cnt=0; disp_de in that same cycle SHALL be ignored.
REQ-023 In CAPTURE, each cycle with disp_de=1 SHALL form {pix_cnt, r, g, b}, push it if the FIFO is not full, and increment pix_cnt whether or not the push succeeds.
REQ-024 A push refused because the FIFO is full SHALL drop the pixel and set overflow; fullness SHALL use the count at the start of the cycle, so a pop in the same cycle does not make room.
REQ-025 A disp_de pixel with pix_cnt = H_RES*V_RES-1 SHALL be handled as in REQ-023, then go to DRAIN.
REQ-026 disp_frame=1 in CAPTURE SHALL set frame_err and go to DRAIN; disp_de in that cycle SHALL be ignored.
REQ-027 DRAIN SHALL go to DONE in the cycle after the FIFO becomes empty; stream inputs SHALL be ignored in DRAIN.
REQ-028 mem_valid SHALL equal FIFO non-empty (first-word fall-through); mem_addr and mem_data SHALL present the head entry.
REQ-029 A transfer SHALL occur on mem_valid & mem_ready; while mem_valid=1 and mem_ready=0, mem_addr and mem_data SHALL stay stable.
REQ-030 A pixel pushed into an empty FIFO in cycle N SHALL appear on mem_* in cycle N+1.
REQ-031 The FIFO SHALL support push and pop in the same cycle, with the count unchanged.
REQ-032 The FIFO SHALL preserve pixel order; mem_addr values SHALL be strictly increasing within one capture.
REQ-033 Per frame, accepted writes plus dropped pixels SHALL equal pix_cnt at exit from CAPTURE.

Reset
REQ-034 rst_pix=1 SHALL force IDLE, flush the FIFO and zero pix_cnt, from any state including mid-capture.
REQ-035 During and after reset, mem_valid, busy, done, overflow and frame_err SHALL be 0 and mem_addr and mem_data SHALL be 0.
REQ-036 No write SHALL issue in the cycle after reset deasserts.

Verification (H_RES=4, V_RES=2, FIFO_DEPTH=4 unless stated)
REQ-037 Basic: cap_start, then frame pulse, then 2 lines of 4 de pixels, data=index, mem_ready=1 -> 8 writes, addr 0..7, data 0..7, done pulses once, overflow=0.
REQ-038 Backpressure: mem_ready=0 throughout the frame -> 4 writes queued, pixels 4..7 dropped, overflow=1; then mem_ready=1 -> addr 0..3 drain in order, done.
REQ-039 Stall stability: mem_ready toggled every other cycle -> mem_addr and mem_data stay constant whenever valid&!ready, and no write is lost.
REQ-040 Short frame: frame pulse after 5 pixels -> frame_err=1, addr 0..4 written, done; the next cap_start clears frame_err.
REQ-041 Arming: de pixels before the frame pulse, and a pixel coincident with it -> none captured; cap_start while busy ignored.
REQ-042 Reset mid-capture: rst_pix after 3 pixels with mem_ready=0 -> next cycle mem_valid=0, busy=0, and no stale write after release.
